// File: rtl/seq_detect_prog_pkg.sv
// Shared types and defaults for the programmable serial pattern detector.
package seq_detect_pkg;

    // Detector state: FILL while fewer than len valid bits are held, ARMED after.
    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } state_t;

    // Width needed to hold any length from 0 to pat_w inclusive.
    function automatic int calc_len_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // Reset-time configuration: pattern 1001, length 4, overlap on.
    localparam logic [7:0] DEF_PAT_C = 8'b0000_1001;
    localparam int         DEF_LEN_C = 4;
    localparam bit         DEF_OVL_C = 1'b1;

endpackage

// File: rtl/seq_detect_prog_if.sv
// Bit-stream, configuration and status signals of the pattern detector.
interface seq_detect_prog_if #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8
);
    import seq_detect_pkg::*;

    localparam int LEN_W = calc_len_w(PAT_W);

    logic             din;
    logic             din_valid;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             cnt_clr;
    logic             flag;
    logic [CNT_W-1:0] match_cnt;
    logic             cfg_err;
    logic [LEN_W-1:0] cur_len;

    // Bit source / control side.
    modport master (
        output din, din_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        input  flag, match_cnt, cfg_err, cur_len
    );

    // Detector side.
    modport slave (
        input  din, din_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        output flag, match_cnt, cfg_err, cur_len
    );

endinterface

// File: rtl/seq_detect_prog_sat_counter.sv
// Saturating up-counter with clear taking priority over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    // Count up on inc, hold at all-ones, clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial pattern detector with overlap control and
// saturating match counter.
module seq_detect_prog
    import seq_detect_pkg::*;
#(
    parameter int               PAT_W   = 8,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(DEF_PAT_C),
    parameter int               DEF_LEN = DEF_LEN_C,
    parameter bit               DEF_OVL = DEF_OVL_C
) (
    input logic               clk,
    input logic               rst_n,
    seq_detect_prog_if.slave  bus
);

    localparam int               LEN_W   = calc_len_w(PAT_W);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);
    localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);

    // Architectural state
    state_t           r_state;
    logic [PAT_W-1:0] r_hist;
    logic [LEN_W-1:0] r_fill;
    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic             r_ovl;
    logic             r_flag;
    logic             r_cfg_err;

    // Next-state values
    state_t           w_state_next;
    logic [PAT_W-1:0] w_hist_next;
    logic [LEN_W-1:0] w_fill_next;
    logic             w_flag_next;
    logic             w_cfg_err_next;
    logic             w_cnt_inc;

    // Decode of this cycle's inputs
    logic             w_load_ok;
    logic             w_load_bad;
    logic             w_shift;
    logic             w_permit;
    logic             w_hit;
    logic             w_match;
    logic [PAT_W:0]   w_cand;
    logic [PAT_W:0]   w_mask;
    logic [LEN_W-1:0] w_fill_inc;
    logic [CNT_W-1:0] w_cnt;

    // Compare mask: only the low len bits of the candidate take part.
    generate
        for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
            assign w_mask[gi] = (LEN_W'(gi) < r_len);
        end
    endgenerate
    assign w_mask[PAT_W] = 1'b0;

    // Candidate window: history with the incoming bit appended at bit 0.
    assign w_cand = {r_hist, bus.din};

    // A legal load takes over the cycle; an illegal one leaves the stream untouched.
    assign w_load_ok  = bus.cfg_load && (bus.cfg_len != '0) && (bus.cfg_len <= MAX_LEN);
    assign w_load_bad = bus.cfg_load && !w_load_ok;
    assign w_shift    = bus.din_valid && !w_load_ok;

    // Matching is allowed once the new bit completes len bits of history.
    assign w_permit = (r_state == ARMED) || (r_fill == (r_len - ONE_LEN));
    assign w_hit    = ((w_cand ^ {1'b0, r_pat}) & w_mask) == '0;
    assign w_match  = w_shift && w_permit && w_hit;

    // Fill count saturates at PAT_W; it can only exceed len in ARMED.
    assign w_fill_inc = (r_fill < MAX_LEN) ? (r_fill + ONE_LEN) : r_fill;

    // State register and datapath registers, updated together each edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= FILL;
            r_hist    <= '0;
            r_fill    <= '0;
            r_pat     <= DEF_PAT;
            r_len     <= LEN_W'(DEF_LEN);
            r_ovl     <= DEF_OVL;
            r_flag    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_hist    <= w_hist_next;
            r_fill    <= w_fill_next;
            r_flag    <= w_flag_next;
            r_cfg_err <= w_cfg_err_next;
            if (w_load_ok) begin
                r_pat <= bus.cfg_pattern;
                r_len <= bus.cfg_len;
                r_ovl <= bus.cfg_overlap;
            end
        end
    end

    // Next state plus history/fill: loads and non-overlap matches restart collection.
    always_comb begin
        w_state_next = r_state;
        w_hist_next  = r_hist;
        w_fill_next  = r_fill;

        if (w_load_ok || (w_match && !r_ovl)) begin
            w_hist_next = '0;
            w_fill_next = '0;
        end else if (w_shift) begin
            w_hist_next = w_cand[PAT_W-1:0];
            w_fill_next = w_fill_inc;
        end

        case (r_state)
            FILL: begin
                if (w_load_ok || (w_match && !r_ovl)) begin
                    w_state_next = FILL;
                end else if (w_shift && ((r_fill + ONE_LEN) >= r_len)) begin
                    w_state_next = ARMED;
                end
            end
            ARMED: begin
                if (w_load_ok || (w_match && !r_ovl)) begin
                    w_state_next = FILL;
                end
            end
            default: w_state_next = FILL;
        endcase
    end

    // Outputs for the next cycle: match pulse, rejected-load pulse, count step.
    always_comb begin
        w_flag_next    = w_match;
        w_cfg_err_next = w_load_bad;
        w_cnt_inc      = w_match;
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_cnt_inc),
        .clr   (bus.cnt_clr),
        .q     (w_cnt)
    );

    assign bus.flag      = r_flag;
    assign bus.cfg_err   = r_cfg_err;
    assign bus.match_cnt = w_cnt;
    assign bus.cur_len   = r_len;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: directed scenarios plus random stream against a
// queue-based reference model of the detector.
module tb_seq_detect_prog;
    import seq_detect_pkg::*;

    localparam int PAT_W   = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = calc_len_w(PAT_W);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_detect_prog_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

    seq_detect_prog #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;
    int pulses   = 0;

    // Reference model: received bits oldest-first, plus active configuration.
    bit         hq[$];
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl;
    int         m_cnt;
    int         e_flag;
    int         e_err;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc_n, got, exp);
        end
    endtask

    // True when the last len-1 stored bits followed by d spell the pattern MSB-first.
    function automatic bit model_hit(input bit d);
        int n;
        n = m_len;
        if (hq.size() < n - 1) return 1'b0;
        for (int i = 0; i < n - 1; i++) begin
            if (hq[hq.size() - (n - 1) + i] != m_pat[n - 1 - i]) return 1'b0;
        end
        return d == m_pat[0];
    endfunction

    task automatic model_reset();
        hq.delete();
        m_pat  = DEF_PAT_C;
        m_len  = DEF_LEN_C;
        m_ovl  = DEF_OVL_C;
        m_cnt  = 0;
        e_flag = 0;
        e_err  = 0;
    endtask

    // One clock: drive inputs, advance model, sample outputs 1 time unit after the edge.
    task automatic cyc(input bit d, input bit v, input bit ld = 0, input int pat = 0,
                       input int len = 0, input bit ovl = 0, input bit clr = 0, input bit rst = 0);
        bit hit;
        bit lok;
        rst_n           = !rst;
        bus.din         = d;
        bus.din_valid   = v;
        bus.cfg_load    = ld;
        bus.cfg_pattern = PAT_W'(pat);
        bus.cfg_len     = LEN_W'(len);
        bus.cfg_overlap = ovl;
        bus.cnt_clr     = clr;

        hit = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            lok   = ld && (len >= 1) && (len <= PAT_W);
            e_err = (ld && !lok) ? 1 : 0;
            if (lok) begin
                hq.delete();
                m_pat = 8'(pat);
                m_len = len;
                m_ovl = ovl;
            end else if (v) begin
                hit = model_hit(d);
                if (hit && !m_ovl) begin
                    hq.delete();
                end else begin
                    hq.push_back(d);
                    if (hq.size() > PAT_W) void'(hq.pop_front());
                end
            end
            e_flag = hit ? 1 : 0;
            if (clr)                       m_cnt = 0;
            else if (hit && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end

        @(posedge clk);
        #1;
        cyc_n++;
        if (bus.flag === 1'b1) pulses++;
        $display("cyc %0d rst=%0b d=%0b v=%0b ld=%0b len=%0d clr=%0b -> flag=%0b err=%0b cnt=%0d cur_len=%0d",
                 cyc_n, rst, d, v, ld, len, clr, bus.flag, bus.cfg_err, bus.match_cnt, bus.cur_len);
        check_val("flag",    32'(bus.flag),      32'(e_flag));
        check_val("cfg_err", 32'(bus.cfg_err),   32'(e_err));
        check_val("cnt",     32'(bus.match_cnt), 32'(m_cnt));
        check_val("cur_len", 32'(bus.cur_len),   32'(m_len));
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) cyc(bits[i], 1'b1);
    endtask

    initial begin
        logic [15:0] s7;
        logic [7:0]  a5;
        s7 = 16'b1001001;
        a5 = 8'hA5;
        model_reset();

        // Reset state
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        check_val("rst_flag", 32'(bus.flag), 0);
        check_val("rst_cnt",  32'(bus.match_cnt), 0);
        check_val("rst_len",  32'(bus.cur_len), 4);

        // Default config, overlap: two pulses
        pulses = 0;
        send_bits(s7, 7);
        check_val("def_pulses", 32'(pulses), 2);
        check_val("def_cnt", 32'(bus.match_cnt), 2);

        // Non-overlap: one pulse
        cyc(0, 0, 1, 9, 4, 0, 1);
        pulses = 0;
        send_bits(s7, 7);
        check_val("novl_pulses", 32'(pulses), 1);
        check_val("novl_cnt", 32'(bus.match_cnt), 1);

        // Full length with random gaps
        cyc(0, 0, 1, 8'hA5, 8, 1, 1);
        pulses = 0;
        for (int i = 7; i >= 0; i--) begin
            int gaps;
            gaps = $urandom_range(0, 3);
            for (int g = 0; g < gaps; g++) cyc(1'($urandom), 1'b0);
            cyc(a5[i], 1'b1);
            if (i == 0) check_val("a5_flag_lat", 32'(bus.flag), 1);
        end
        cyc(0, 0);
        check_val("a5_pulses", 32'(pulses), 1);

        // Illegal lengths leave configuration unchanged
        cyc(0, 0, 1, 3, 0, 1);
        check_val("len0_err", 32'(bus.cfg_err), 1);
        check_val("len0_cur", 32'(bus.cur_len), 8);
        cyc(0, 0, 1, 3, PAT_W + 1, 1);
        check_val("len9_err", 32'(bus.cfg_err), 1);
        check_val("len9_cur", 32'(bus.cur_len), 8);
        cyc(0, 0);
        check_val("err_width", 32'(bus.cfg_err), 0);

        // Length 1, pattern 1: stream 1,1,0,1 gives three pulses
        cyc(0, 0, 1, 1, 1, 1, 1);
        pulses = 0;
        send_bits(16'b1101, 4);
        check_val("len1_pulses", 32'(pulses), 3);

        // Clear on a match cycle: clear wins, flag still pulses
        cyc(1, 1, 0, 0, 0, 0, 1);
        check_val("clr_flag", 32'(bus.flag), 1);
        check_val("clr_cnt", 32'(bus.match_cnt), 0);

        // Saturation at 3 after 5 matches
        for (int i = 0; i < 5; i++) cyc(1, 1);
        check_val("sat_cnt", 32'(bus.match_cnt), 3);

        // Reset mid-stream discards partial history
        cyc(0, 0, 1, 9, 4, 1, 1);
        send_bits(16'b100, 3);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        pulses = 0;
        cyc(1, 1);
        check_val("rst_mid_pulses", 32'(pulses), 0);

        // Reload mid-stream discards partial history and the load-cycle bit
        send_bits(16'b100, 3);
        cyc(1, 1, 1, 9, 4, 1);
        pulses = 0;
        cyc(1, 1);
        check_val("load_mid_pulses", 32'(pulses), 0);

        // Random stream against the model
        for (int i = 0; i < 2000; i++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 5) begin
                cyc(1'($urandom), 1'($urandom), 0, 0, 0, 0, 0, 1);
            end else if (r < 35) begin
                cyc(1'($urandom), 1'($urandom), 1, $urandom_range(0, 255),
                    $urandom_range(0, 15), 1'($urandom), 1'($urandom_range(0, 9) == 0));
            end else begin
                cyc(1'($urandom), 1'($urandom_range(0, 3) != 0), 0, 0, 0, 0,
                    1'($urandom_range(0, 19) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
